player_input_conditioner: RTL and testbench
===========================================

Name: player_input_conditioner

Overview:
- Front-end stage for one player, one instance per player (P1, P2), sitting directly upstream of memory_map.
- Synchronizes and debounces the raw gun-trigger and IR-sensor pins.
- Enforces fire-rate cooldown and a hit hold-off.
- Drives memory_map's p1_trigger/p1_sens (or p2_*) with clean single-cycle event pulses, so memory_map never sees bounce or held levels.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles before the trigger level is accepted.
- COOLDOWN_CYCLES, 24'd5000000, minimum cycles between two shot pulses.
- SENS_MIN_CYCLES, 16'd1000, consecutive sensor-high cycles that qualify as a hit.
- HOLDOFF_CYCLES, 24'd10000000, cycles after a hit during which further hits are ignored.
- CNT_W, 24, width of every internal counter. All cycle parameters must be < 2**CNT_W.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous, active-low reset.
- enable  in  1  game active. When 0, no pulses are emitted and counters hold in idle.
- trigger_raw  in  1  asynchronous gun trigger pin, high = pressed.
- sens_raw  in  1  asynchronous IR sensor pin, high = carrier detected.
- trigger_out  out  1  one-cycle shot event to memory_map p*_trigger.
- sens_out  out  1  one-cycle hit event to memory_map p*_sens.
- fire_busy  out  1  high while cooldown is running.
- hit_lock  out  1  high during the hit hold-off.
- shot_count  out  8  total accepted shots, wraps 255->0.

Behaviour:
- Reset (CLR=0, asynchronous): all outputs 0, synchronizer flops 0, counters 0, trigger FSM = T_IDLE, sensor FSM = S_IDLE.
- Synchronizers: each raw input passes through a 2-flop synchronizer. All logic below uses the synced signals only.
- Debounce (trigger only):
  - A counter increments while synced level differs from the debounced level, and clears on any match.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Trigger FSM:
  - T_IDLE: on a debounced rising edge with enable=1 -> T_FIRE.
  - T_FIRE (1 cycle): trigger_out=1, shot_count+1 -> T_COOLDOWN.
  - T_COOLDOWN: fire_busy=1, counter counts COOLDOWN_CYCLES. On expiry -> T_WAIT_REL if debounced trigger is still high, else T_IDLE.
  - T_WAIT_REL: on debounced low -> T_IDLE.
- Trigger latency: trigger_out rises on the (2+DEBOUNCE_CYCLES+1)th rising CLK edge after trigger_raw is first sampled high and held stable.
- Sensor FSM:
  - S_IDLE: counts consecutive synced-high cycles; any low clears the count. When the count reaches SENS_MIN_CYCLES and enable=1 -> S_HIT.
  - S_HIT (1 cycle): sens_out=1 -> S_HOLD.
  - S_HOLD: hit_lock=1 for HOLDOFF_CYCLES, then -> S_IDLE with the count cleared. The sensor must return low and re-qualify before another hit.
- Simultaneous trigger and hit in the same cycle: both pulses are emitted; the FSMs are independent.
- enable falling mid-operation: both FSMs return to idle on the next edge, with counters cleared and no pulse. fire_busy and hit_lock drop.
- Edges during T_COOLDOWN or S_HOLD are discarded, not queued.
- Reset mid-pulse: the pulse is truncated immediately (asynchronous).

Optional Feature:
- AUTO_FIRE_EN.
- Defined: on T_COOLDOWN expiry with debounced trigger still high and enable=1, the FSM goes directly to T_FIRE instead of T_WAIT_REL. Holding the trigger yields one shot every COOLDOWN_CYCLES+1 cycles.
- Undefined: T_WAIT_REL as above; one shot per press.

Decomposition:
- Shared include player_io_defs.vh holds:
  - T_IDLE/T_FIRE/T_COOLDOWN/T_WAIT_REL encodings (2-bit).
  - S_IDLE/S_HIT/S_HOLD encodings (2-bit).
  - Default cycle-count constants.
- One natural sub-module: sync_debounce (2-flop sync + debounce counter, parameter DEBOUNCE_CYCLES).
  - Instantiated for trigger.
  - Sensor uses its sync stage with debounce bypassed (DEBOUNCE_CYCLES=0 path = sync only).

Test Plan (bench parameters DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10, SENS_MIN_CYCLES=3, HOLDOFF_CYCLES=8, enable=1):
- Clean press: trigger_raw 0->1 and held 30 cycles -> exactly one trigger_out pulse on edge 7; fire_busy high for 10 cycles; shot_count=1.
- Bounce: trigger_raw toggles every 2 cycles for 20 cycles, then stays 0 -> no trigger_out; shot_count=0.
- Press during cooldown: second clean press starting 3 cycles after the first pulse -> no second pulse; shot_count=1. Without AUTO_FIRE_EN, holding 40 cycles also gives 1 shot. With AUTO_FIRE_EN, holding 40 cycles gives pulses at edges 7, 18, 29, 40.
- Hit qualification:
  - sens_raw high 2 cycles, low, then high 3 cycles -> single sens_out pulse 1 cycle after the 3rd synced-high cycle.
  - Hit_lock then stays high 8 cycles; a sens_raw held high throughout yields no second hit.
- Simultaneous + enable drop: trigger and sensor qualify on the same edge -> trigger_out and sens_out both 1 that cycle. Then enable=0 during cooldown -> fire_busy=0 next edge; the next press with enable=0 gives no pulse.
- Async reset: CLR=0 for 1 ns mid-cooldown with shot_count=3 -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/player_input_conditioner_pkg.sv
// Shared state encodings and default cycle counts for the player input conditioner.
// Replaces the old player_io_defs.vh include; import with player_input_conditioner_pkg::*.
package player_input_conditioner_pkg;

   typedef enum logic [1:0] {
      T_IDLE     = 2'd0,
      T_FIRE     = 2'd1,
      T_COOLDOWN = 2'd2,
      T_WAIT_REL = 2'd3
   } trig_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIT  = 2'd1,
      S_HOLD = 2'd2
   } sens_state_t;

   localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [23:0] DEF_COOLDOWN_CYCLES = 24'd5000000;
   localparam logic [15:0] DEF_SENS_MIN_CYCLES = 16'd1000;
   localparam logic [23:0] DEF_HOLDOFF_CYCLES  = 24'd10000000;
   localparam int          DEF_CNT_W           = 24;

endpackage

// File: rtl/player_input_conditioner_sync_debounce.sv
// Two-flop synchronizer with optional level debounce; DEBOUNCE_CYCLES = 0 gives sync only.
module player_input_conditioner_sync_debounce #(
   parameter int               CNT_W           = 24,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = '0
) (
   input  logic CLK,
   input  logic CLR,
   input  logic din_raw,
   output logic level
);

   logic [1:0] sync_q;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) sync_q <= 2'b00;
      else      sync_q <= {sync_q[0], din_raw};
   end

   generate
      if (DEBOUNCE_CYCLES == '0) begin : g_bypass
         assign level = sync_q[1];
      end else begin : g_debounce
         localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);
         logic [CNT_W-1:0] cnt_q;
         logic             level_q;

         // Counter tracks how long the synced level has disagreed with the accepted level.
         always_ff @(posedge CLK or negedge CLR) begin
            if (!CLR) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else if (sync_q[1] == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
               level_q <= sync_q[1];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end

         assign level = level_q;
      end
   endgenerate

endmodule

// File: rtl/player_input_conditioner.sv
// Per-player trigger/sensor conditioner feeding memory_map with single-cycle shot and hit events.
// Build option: define AUTO_FIRE_EN to re-fire directly after cooldown while the trigger stays held.
//
// state      | meaning
// T_IDLE     | waiting for a debounced trigger press
// T_FIRE     | one-cycle shot pulse, shot_count advances
// T_COOLDOWN | fire-rate cooldown, presses ignored
// T_WAIT_REL | trigger still held after cooldown, waiting for release
// S_IDLE     | qualifying consecutive sensor-high cycles
// S_HIT      | one-cycle hit pulse
// S_HOLD     | hit hold-off, further hits ignored
module player_input_conditioner
   import player_input_conditioner_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [23:0] COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter logic [15:0] SENS_MIN_CYCLES = DEF_SENS_MIN_CYCLES,
   parameter logic [23:0] HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter int          CNT_W           = DEF_CNT_W
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       enable,
   input  logic       trigger_raw,
   input  logic       sens_raw,
   output logic       trigger_out,
   output logic       sens_out,
   output logic       fire_busy,
   output logic       hit_lock,
   output logic [7:0] shot_count
);

   localparam logic [CNT_W-1:0] CD_LOAD   = (COOLDOWN_CYCLES == 24'd0) ? '0 : CNT_W'(COOLDOWN_CYCLES - 24'd1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF_CYCLES == 24'd0)  ? '0 : CNT_W'(HOLDOFF_CYCLES - 24'd1);
   localparam logic [CNT_W-1:0] SENS_LAST = (SENS_MIN_CYCLES == 16'd0) ? '0 : CNT_W'(SENS_MIN_CYCLES - 16'd1);

   trig_state_t      t_state_q, t_state_d;
   sens_state_t      s_state_q, s_state_d;
   logic             trig_lvl, trig_lvl_q, trig_rise;
   logic             sens_sync, sens_armed_q;
   logic [CNT_W-1:0] cd_cnt_q, s_cnt_q;

   player_input_conditioner_sync_debounce #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(CNT_W'(DEBOUNCE_CYCLES))
   ) u_trig_sync (
      .CLK    (CLK),
      .CLR    (CLR),
      .din_raw(trigger_raw),
      .level  (trig_lvl)
   );

   player_input_conditioner_sync_debounce #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES('0)
   ) u_sens_sync (
      .CLK    (CLK),
      .CLR    (CLR),
      .din_raw(sens_raw),
      .level  (sens_sync)
   );

   assign trig_rise = trig_lvl & ~trig_lvl_q;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         t_state_q  <= T_IDLE;
         s_state_q  <= S_IDLE;
         trig_lvl_q <= 1'b0;
      end else begin
         t_state_q  <= t_state_d;
         s_state_q  <= s_state_d;
         trig_lvl_q <= trig_lvl;
      end
   end

   always_comb begin
      t_state_d = t_state_q;
      if (!enable) begin
         t_state_d = T_IDLE;
      end else begin
         case (t_state_q)
            T_IDLE:     if (trig_rise) t_state_d = T_FIRE;
            T_FIRE:     t_state_d = T_COOLDOWN;
            T_COOLDOWN: if (cd_cnt_q == '0) begin
`ifdef AUTO_FIRE_EN
                           t_state_d = trig_lvl ? T_FIRE : T_IDLE;
`else
                           t_state_d = trig_lvl ? T_WAIT_REL : T_IDLE;
`endif
                        end
            T_WAIT_REL: if (!trig_lvl) t_state_d = T_IDLE;
            default:    t_state_d = T_IDLE;
         endcase
      end
   end

   always_comb begin
      trigger_out = (t_state_q == T_FIRE);
      fire_busy   = (t_state_q == T_COOLDOWN);
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         cd_cnt_q   <= '0;
         shot_count <= 8'd0;
      end else begin
         if (t_state_q == T_FIRE) shot_count <= shot_count + 8'd1;
         if (!enable)                                          cd_cnt_q <= '0;
         else if (t_state_q == T_FIRE)                         cd_cnt_q <= CD_LOAD;
         else if (t_state_q == T_COOLDOWN && cd_cnt_q != '0)   cd_cnt_q <= cd_cnt_q - CNT_W'(1);
         else                                                  cd_cnt_q <= '0;
      end
   end

   always_comb begin
      s_state_d = s_state_q;
      if (!enable) begin
         s_state_d = S_IDLE;
      end else begin
         case (s_state_q)
            S_IDLE:  if (sens_armed_q && sens_sync && s_cnt_q == SENS_LAST) s_state_d = S_HIT;
            S_HIT:   s_state_d = S_HOLD;
            S_HOLD:  if (s_cnt_q == '0) s_state_d = S_IDLE;
            default: s_state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      sens_out = (s_state_q == S_HIT);
      hit_lock = (s_state_q == S_HOLD);
   end

   // One counter serves both qualification (counting up) and hold-off (counting down).
   // A hit disarms the sensor until it has been seen low again.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         s_cnt_q      <= '0;
         sens_armed_q <= 1'b0;
      end else begin
         if (s_state_q == S_HIT) sens_armed_q <= 1'b0;
         else if (!sens_sync)    sens_armed_q <= 1'b1;

         if (!enable) begin
            s_cnt_q <= '0;
         end else begin
            case (s_state_q)
               S_IDLE:  s_cnt_q <= (sens_armed_q && sens_sync && s_cnt_q != SENS_LAST) ? s_cnt_q + CNT_W'(1) : '0;
               S_HIT:   s_cnt_q <= HOLD_LOAD;
               S_HOLD:  s_cnt_q <= (s_cnt_q != '0) ? s_cnt_q - CNT_W'(1) : '0;
               default: s_cnt_q <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: expected pulse cycles are queued at stimulus time
// and matched against observed trigger_out/sens_out pulses on every falling edge.
module tb_player_input_conditioner;

   logic       CLK = 1'b0;
   logic       CLR;
   logic       enable;
   logic       trigger_raw;
   logic       sens_raw;
   logic       trigger_out;
   logic       sens_out;
   logic       fire_busy;
   logic       hit_lock;
   logic [7:0] shot_count;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         trig_q[$];
   int         sens_q[$];
   logic [7:0] exp_shots = 8'd0;

   player_input_conditioner #(
      .DEBOUNCE_CYCLES(16'd4),
      .COOLDOWN_CYCLES(24'd10),
      .SENS_MIN_CYCLES(16'd3),
      .HOLDOFF_CYCLES (24'd8),
      .CNT_W          (24)
   ) dut (
      .CLK        (CLK),
      .CLR        (CLR),
      .enable     (enable),
      .trigger_raw(trigger_raw),
      .sens_raw   (sens_raw),
      .trigger_out(trigger_out),
      .sens_out   (sens_out),
      .fire_busy  (fire_busy),
      .hit_lock   (hit_lock),
      .shot_count (shot_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Advance n falling edges; every observed pulse is matched against the scoreboard.
   task automatic tick(input int n);
      int e;
      repeat (n) begin
         @(negedge CLK);
         if (trigger_out === 1'b1) begin
            checks++;
            if (trig_q.size() == 0) begin
               errors++;
               $display("FAIL trig_pulse: pulse at cycle %0d, required no pulse", cyc);
            end else begin
               e = trig_q.pop_front();
               if (cyc !== e) begin
                  errors++;
                  $display("FAIL trig_pulse: pulse at cycle %0d, required cycle %0d", cyc, e);
               end
            end
         end
         if (sens_out === 1'b1) begin
            checks++;
            if (sens_q.size() == 0) begin
               errors++;
               $display("FAIL sens_pulse: pulse at cycle %0d, required no pulse", cyc);
            end else begin
               e = sens_q.pop_front();
               if (cyc !== e) begin
                  errors++;
                  $display("FAIL sens_pulse: pulse at cycle %0d, required cycle %0d", cyc, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset;
      CLR = 1'b0; enable = 1'b0; trigger_raw = 1'b0; sens_raw = 1'b0;
      #2;
      checks++; if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trigger_out: got %b want 0", trigger_out); end
      checks++; if (sens_out !== 1'b0)    begin errors++; $display("FAIL reset_sens_out: got %b want 0", sens_out); end
      checks++; if (fire_busy !== 1'b0)   begin errors++; $display("FAIL reset_fire_busy: got %b want 0", fire_busy); end
      checks++; if (hit_lock !== 1'b0)    begin errors++; $display("FAIL reset_hit_lock: got %b want 0", hit_lock); end
      checks++; if (shot_count !== 8'd0)  begin errors++; $display("FAIL reset_shot_count: got %0d want 0", shot_count); end
      @(negedge CLK);
      CLR = 1'b1; enable = 1'b1;
      tick(3);
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 10; i++) begin
         trigger_raw = (i % 2 == 0);
         tick(2);
      end
      trigger_raw = 1'b0;
      tick(10);
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL bounce_shot_count: got %0d want %0d", shot_count, exp_shots); end
      checks++; if (fire_busy !== 1'b0) begin errors++; $display("FAIL bounce_fire_busy: got %b want 0", fire_busy); end
   endtask

   task automatic test_clean_press;
      int t0, busy_n, busy_first;
      t0 = cyc; busy_n = 0; busy_first = -1;
      trigger_raw = 1'b1;
      trig_q.push_back(t0 + 7); exp_shots++;
`ifdef AUTO_FIRE_EN
      trig_q.push_back(t0 + 18); trig_q.push_back(t0 + 29); exp_shots += 8'd2;
`endif
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (fire_busy === 1'b1) begin
            if (i <= 17) busy_n++;
            if (busy_first < 0) busy_first = cyc;
         end
      end
      trigger_raw = 1'b0;
      tick(12);
      checks++; if (busy_n != 10) begin errors++; $display("FAIL press_busy_len: got %0d cycles want 10", busy_n); end
      checks++; if (busy_first != t0 + 8) begin errors++; $display("FAIL press_busy_start: got cycle %0d want %0d", busy_first, t0 + 8); end
      checks++; if (trig_q.size() != 0) begin errors++; $display("FAIL press_missing: %0d pulses still expected, want 0", trig_q.size()); end
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL press_shot_count: got %0d want %0d", shot_count, exp_shots); end
      checks++; if (fire_busy !== 1'b0) begin errors++; $display("FAIL press_idle_busy: got %b want 0", fire_busy); end
   endtask

   task automatic test_cooldown_press;
      int t0;
      t0 = cyc;
      trigger_raw = 1'b1;
      trig_q.push_back(t0 + 7); exp_shots++;
      tick(8);
      trigger_raw = 1'b0;
      tick(2);
      trigger_raw = 1'b1;
`ifdef AUTO_FIRE_EN
      trig_q.push_back(t0 + 18); trig_q.push_back(t0 + 29);
      trig_q.push_back(t0 + 40); trig_q.push_back(t0 + 51);
      exp_shots += 8'd4;
`endif
      tick(40);
      trigger_raw = 1'b0;
      tick(25);
      checks++; if (trig_q.size() != 0) begin errors++; $display("FAIL cooldown_missing: %0d pulses still expected, want 0", trig_q.size()); end
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL cooldown_shot_count: got %0d want %0d", shot_count, exp_shots); end
      checks++; if (fire_busy !== 1'b0) begin errors++; $display("FAIL cooldown_idle_busy: got %b want 0", fire_busy); end
   endtask

   task automatic test_hit;
      int t0, lock_n, lock_first;
      t0 = cyc; lock_n = 0; lock_first = -1;
      sens_raw = 1'b1;
      sens_q.push_back(t0 + 8);
      tick(2);
      sens_raw = 1'b0;
      tick(1);
      sens_raw = 1'b1;
      for (int i = 0; i < 27; i++) begin
         tick(1);
         if (hit_lock === 1'b1) begin
            lock_n++;
            if (lock_first < 0) lock_first = cyc;
         end
      end
      sens_raw = 1'b0;
      tick(6);
      checks++; if (lock_n != 8) begin errors++; $display("FAIL hit_lock_len: got %0d cycles want 8", lock_n); end
      checks++; if (lock_first != t0 + 9) begin errors++; $display("FAIL hit_lock_start: got cycle %0d want %0d", lock_first, t0 + 9); end
      checks++; if (sens_q.size() != 0) begin errors++; $display("FAIL hit_missing: %0d pulses still expected, want 0", sens_q.size()); end
      checks++; if (hit_lock !== 1'b0) begin errors++; $display("FAIL hit_idle_lock: got %b want 0", hit_lock); end
   endtask

   task automatic test_simultaneous_enable_drop;
      int t0;
      t0 = cyc;
      trigger_raw = 1'b1;
      trig_q.push_back(t0 + 7); exp_shots++;
      tick(2);
      sens_raw = 1'b1;
      sens_q.push_back(t0 + 7);
      tick(8);
      checks++; if (fire_busy !== 1'b1) begin errors++; $display("FAIL sim_busy_before_drop: got %b want 1", fire_busy); end
      checks++; if (hit_lock !== 1'b1)  begin errors++; $display("FAIL sim_lock_before_drop: got %b want 1", hit_lock); end
      enable = 1'b0;
      tick(1);
      checks++; if (fire_busy !== 1'b0) begin errors++; $display("FAIL drop_fire_busy: got %b want 0", fire_busy); end
      checks++; if (hit_lock !== 1'b0)  begin errors++; $display("FAIL drop_hit_lock: got %b want 0", hit_lock); end
      trigger_raw = 1'b0; sens_raw = 1'b0;
      tick(10);
      trigger_raw = 1'b1;
      tick(15);
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL disabled_shot_count: got %0d want %0d", shot_count, exp_shots); end
      checks++; if (trig_q.size() != 0 || sens_q.size() != 0) begin errors++; $display("FAIL sim_missing: trig %0d sens %0d pending, want 0 0", trig_q.size(), sens_q.size()); end
      trigger_raw = 1'b0;
      tick(10);
      enable = 1'b1;
      tick(3);
   endtask

   task automatic test_async_reset;
      int t0;
      CLR = 1'b0;
      tick(1);
      CLR = 1'b1; exp_shots = 8'd0;
      tick(2);
      for (int k = 0; k < 2; k++) begin
         t0 = cyc;
         trigger_raw = 1'b1;
         trig_q.push_back(t0 + 7); exp_shots++;
         tick(8);
         trigger_raw = 1'b0;
         tick(20);
      end
      t0 = cyc;
      trigger_raw = 1'b1;
      trig_q.push_back(t0 + 7); exp_shots++;
      tick(12);
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL pre_reset_shot_count: got %0d want %0d", shot_count, exp_shots); end
      checks++; if (fire_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", fire_busy); end
      #2;
      CLR = 1'b0; trigger_raw = 1'b0;
      #1;
      checks++; if (shot_count !== 8'd0) begin errors++; $display("FAIL async_shot_count: got %0d want 0", shot_count); end
      checks++; if (fire_busy !== 1'b0)  begin errors++; $display("FAIL async_fire_busy: got %b want 0", fire_busy); end
      checks++; if (trigger_out !== 1'b0 || sens_out !== 1'b0 || hit_lock !== 1'b0) begin
         errors++; $display("FAIL async_pulses: trig %b sens %b lock %b want 0 0 0", trigger_out, sens_out, hit_lock);
      end
      #1;
      CLR = 1'b1; exp_shots = 8'd0;
      tick(12);
      checks++; if (trig_q.size() != 0) begin errors++; $display("FAIL reset_missing: %0d pulses still expected, want 0", trig_q.size()); end
      checks++; if (shot_count !== exp_shots) begin errors++; $display("FAIL post_reset_shot_count: got %0d want %0d", shot_count, exp_shots); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_clean_press();
      test_cooldown_press();
      test_hit();
      test_simultaneous_enable_drop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
